mac_tx_framer: RTL and testbench
================================

// Module: mac_tx_framer
// PURPOSE
// - Upstream feeder for the byte serializer (mac_controller). Buffers host payload bytes in a FIFO, store-and-forward.
// - Wraps each frame with preamble + SFD (optional checksum) and hands bytes one at a time to the serializer over its tx_req/tx_done handshake.
// - Inserts an idle gap between frames.
// PARAMETERS
// - FIFO_DEPTH     16     payload FIFO entries; power of 2, >=4; each entry is {last, data[7:0]}
// - PREAMBLE_LEN   2      preamble bytes per frame, 1..15
// - PREAMBLE_BYTE  8'h55  preamble byte value
// - SFD_BYTE       8'hD5  start-of-frame delimiter value
// - GAP_CYCLES     12     idle clk cycles after a frame's final ser_done, 0..255
// PORTS
// - clk         in   1  clock, rising edge
// - reset       in   1  asynchronous, active-high
// - in_data     in   8  payload byte from host
// - in_valid    in   1  in_data valid
// - in_last     in   1  in_data is the final byte of its frame
// - in_ready    out  1  FIFO can accept; a write occurs when in_valid && in_ready
// - ser_data    out  8  byte to serializer (data_in); held stable from ser_req until ser_done
// - ser_req     out  1  one-cycle request to serializer (tx_req)
// - ser_done    in   1  serializer done level (tx_done)
// - busy        out  1  frame in progress (state != IDLE)
// - frame_sent  out  1  one-cycle pulse when a frame's final byte completes
// BEHAVIOUR
// - Reset: in_ready=0 during reset, then 1; ser_data=0; ser_req=0; busy=0; frame_sent=0.
//   Reset also flushes the FIFO, clears frame_cnt and gap counter, state=IDLE.
// - Reset mid-frame: the frame is aborted and discarded. No ser_req is issued until new data arrives.
// - FIFO: in_ready = !full (registered flags). Push and pop in the same cycle are legal, and the count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
// - frame_cnt counts complete frames in the FIFO:
//   - +1 on a push with in_last; -1 on a pop of a last-tagged entry.
//   - Both in the same cycle: unchanged.
// - Start condition (checked in IDLE): frame_cnt!=0, or FIFO full with frame_cnt==0 (forced start, prevents deadlock on oversize frames).
// - Latency: ser_req for the first preamble byte is asserted 2 cycles after the push cycle carrying in_last (empty FIFO, IDLE).
// - Main FSM: IDLE -> PRE (PREAMBLE_LEN bytes) -> SFD -> DATA -> [FCS] -> GAP -> IDLE.
// - Per-byte handshake sub-phase: ISSUE -> ARM -> WAIT.
//   - ISSUE: ser_data loaded, ser_req=1 for exactly 1 cycle.
//   - ARM: one cycle; ser_done is ignored, because the serializer clears it the cycle after accepting.
//   - WAIT: stay until ser_done==1, then advance to the next byte's ISSUE.
// - DATA: ISSUE pops one FIFO entry into ser_data. DATA ends after the WAIT of the last-tagged entry completes.
// - DATA with FIFO empty (forced start, last not yet written): hold in DATA/ISSUE, ser_req=0, until an entry is present.
// - frame_sent: pulses in the cycle WAIT completes for the final frame byte (last data byte, or the FCS byte when enabled).
// - GAP: counts GAP_CYCLES cycles, ser_req=0. With GAP_CYCLES=0, GAP lasts 0 cycles (direct to IDLE).
// - Pushes continue during any state while !full. Frames are never interleaved.
// - ser_done stuck low: the block waits indefinitely (no timeout).
// CONFIGURATION
// - MAC_TX_FCS_EN defined: an 8-bit XOR checksum of all payload bytes is sent as one extra byte after the last data byte.
//   - The accumulator clears on entry to PRE and updates on each DATA pop.
//   - frame_sent follows the FCS byte.
// - MAC_TX_FCS_EN undefined: no checksum logic; DATA -> GAP directly.
// TESTING
// - Reset, then idle with no writes -> in_ready=1, ser_req never asserts, busy=0.
// - Write 0x12,0x34,0x56(last); serializer model asserts done 10 cycles after req ->
//   ser_data sequence 55,55,D5,12,34,56 (+70 with MAC_TX_FCS_EN), one ser_req per byte, frame_sent once, then >=12 idle cycles before the next ser_req.
// - Hold ser_done high from a previous byte when ser_req pulses -> the framer does not advance until ser_done falls then rises again.
// - Write 16 bytes with no last (FIFO_DEPTH=16) -> in_ready=0, forced start.
//   Then write 0xAA(last) -> all 17 bytes sent in order, frame_sent once.
// - Back-to-back frames {0x01(last)}, {0x02,0x03(last)} written before the first starts -> two separate preamble/SFD sequences, gap between them.
// - Assert reset during the DATA byte 0x34 of the test above -> outputs return to reset values immediately; after release no ser_req until a new frame is written.

Source files
------------

// File: rtl/mac_tx_framer.sv
// Store-and-forward TX framer: payload FIFO, preamble/SFD insertion, per-byte serializer handshake, inter-frame gap.
// Optional checksum byte after the payload when MAC_TX_FCS_EN is defined.
`timescale 1ns/1ps
module mac_tx_framer #(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          PREAMBLE_LEN  = 2,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0]  SFD_BYTE      = 8'hD5,
  parameter int          GAP_CYCLES    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] ser_data,
  output logic       ser_req,
  input  logic       ser_done,
  output logic       busy,
  output logic       frame_sent
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_GAP} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_ISSUE, PH_ARM, PH_WAIT} phase_t;

  state_t      st;
  phase_t      ph;
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next, frame_cnt;
  logic        full, empty;
  logic        push, pop;
  logic [8:0]  rd_entry;
  logic [3:0]  pre_cnt;
  logic [7:0]  gap_cnt;
  logic        cur_last;
`ifdef MAC_TX_FCS_EN
  logic [7:0]  fcs;
`endif

  assign push     = in_valid && in_ready;
  assign rd_entry = mem[rd_ptr];
  // Entries leave the FIFO only when the DATA phase is ready to issue a byte.
  assign pop      = (st == S_DATA) && (ph == PH_LOAD) && !empty;
  assign busy     = (st != S_IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (AW+1)'(1);
    else if (pop && !push) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      in_ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      full     <= (count_next == (AW+1)'(FIFO_DEPTH));
      empty    <= (count_next == '0);
      in_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
      if ((push && in_last) && !(pop && rd_entry[8]))      frame_cnt <= frame_cnt + (AW+1)'(1);
      else if ((pop && rd_entry[8]) && !(push && in_last)) frame_cnt <= frame_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= S_IDLE;
      ph         <= PH_LOAD;
      ser_data   <= 8'h00;
      ser_req    <= 1'b0;
      frame_sent <= 1'b0;
      pre_cnt    <= '0;
      gap_cnt    <= '0;
      cur_last   <= 1'b0;
`ifdef MAC_TX_FCS_EN
      fcs        <= 8'h00;
`endif
    end else begin
      ser_req    <= 1'b0;
      frame_sent <= 1'b0;
      case (st)
        S_IDLE: begin
          // A full FIFO with no complete frame must still drain, or an oversize frame would deadlock.
          if (frame_cnt != '0 || full) begin
            st       <= S_PRE;
            pre_cnt  <= '0;
            ser_data <= PREAMBLE_BYTE;
            ser_req  <= 1'b1;
            ph       <= PH_ISSUE;
`ifdef MAC_TX_FCS_EN
            fcs      <= 8'h00;
`endif
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) st <= S_IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: begin
          case (ph)
            PH_LOAD: begin
              if (pop) begin
                ser_data <= rd_entry[7:0];
                cur_last <= rd_entry[8];
                ser_req  <= 1'b1;
                ph       <= PH_ISSUE;
`ifdef MAC_TX_FCS_EN
                fcs      <= fcs ^ rd_entry[7:0];
`endif
              end
            end
            PH_ISSUE: ph <= PH_ARM;
            // The serializer may still show done from the previous byte here.
            PH_ARM:   ph <= PH_WAIT;
            default: begin
              if (ser_done) begin
                case (st)
                  S_PRE: begin
                    ser_req <= 1'b1;
                    ph      <= PH_ISSUE;
                    if (pre_cnt == 4'(PREAMBLE_LEN - 1)) begin
                      st       <= S_SFD;
                      ser_data <= SFD_BYTE;
                    end else begin
                      pre_cnt <= pre_cnt + 4'd1;
                    end
                  end
                  S_SFD: begin
                    st <= S_DATA;
                    ph <= PH_LOAD;
                  end
                  S_DATA: begin
                    if (!cur_last) begin
                      ph <= PH_LOAD;
                    end else begin
`ifdef MAC_TX_FCS_EN
                      st       <= S_FCS;
                      ser_data <= fcs;
                      ser_req  <= 1'b1;
                      ph       <= PH_ISSUE;
`else
                      frame_sent <= 1'b1;
                      ph         <= PH_LOAD;
                      gap_cnt    <= '0;
                      st         <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
`endif
                    end
                  end
                  default: begin
                    frame_sent <= 1'b1;
                    ph         <= PH_LOAD;
                    gap_cnt    <= '0;
                    st         <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed bench for mac_tx_framer: serializer model with 10-cycle done, byte scoreboard, timing checks.
`timescale 1ns/1ps
module tb_mac_tx_framer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] ser_data;
  logic       ser_req;
  logic       ser_done = 1'b0;
  logic       busy;
  logic       frame_sent;

  mac_tx_framer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .ser_data(ser_data), .ser_req(ser_req), .ser_done(ser_done),
    .busy(busy), .frame_sent(frame_sent)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] frm_q[$];
  logic [7:0] cap_q[$];
  int         req_cyc_q[$];
  int         fs_cyc_q[$];
  int         fs_cnt = 0, run_err = 0, early_err = 0, hold_err = 0;
  int         tests = 0, fails = 0;
  int         cap_rd = 0, push_cyc = 0;

  // serializer model: done stays high through the req and following cycle, drops, rises 10 cycles after req
  int   age = 0, last_req_cyc = 0;
  logic active = 1'b0, prev_req = 1'b0, have_req = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      ser_done = 1'b0; age = 0; active = 1'b0; prev_req = 1'b0; have_req = 1'b0;
    end else begin
      if (ser_req) begin
        cap_q.push_back(ser_data);
        req_cyc_q.push_back(cyc);
        if (prev_req) run_err++;
        if (have_req && (cyc - last_req_cyc) < 11) early_err++;
        have_req = 1'b1; last_req_cyc = cyc; active = 1'b1; age = 0;
      end else if (active) begin
        age++;
        if (age == 2) ser_done = 1'b0;
        if (age == 10) begin
          ser_done = 1'b1;
          active = 1'b0;
          if (ser_data !== cap_q[cap_q.size()-1]) hold_err++;
        end
      end
      prev_req = ser_req;
      if (frame_sent) begin
        fs_cnt++;
        fs_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int waited = 0;
    while (!in_ready && waited < 500) begin
      in_valid = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("push_ready", {31'b0, in_ready}, 32'd1);
    in_data = d; in_valid = 1'b1; in_last = l; push_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // pushes frm_q on consecutive cycles
  task automatic send_frame(input logic with_last);
    for (int i = 0; i < frm_q.size(); i++) begin
      in_data = frm_q[i]; in_valid = 1'b1; in_last = with_last && (i == frm_q.size()-1);
      push_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_frame();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 2; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < frm_q.size(); i++) begin
      exp_q.push_back(frm_q[i]);
      x = x ^ frm_q[i];
    end
`ifdef MAC_TX_FCS_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_sent(input int target);
    int t = 0;
    while (fs_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_sent_count", fs_cnt, target);
  endtask

  task automatic compare_capture(input string tag);
    check({tag, "_len"}, cap_q.size() - cap_rd, exp_q.size());
    while (exp_q.size() > 0 && cap_rd < cap_q.size()) begin
      check(tag, cap_q[cap_rd], exp_q.pop_front());
      cap_rd++;
    end
    exp_q.delete();
    cap_rd = cap_q.size();
  endtask

  initial begin
    int base, fsb, idx, t;
    // reset values
    idle(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_ser_req", ser_req, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_sent", frame_sent, 0);
    check("rst_ser_data", ser_data, 0);
    reset = 1'b0;
    idle(20);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_no_req", cap_q.size(), 0);

    // single frame, latency, no duplicate frame_sent
    base = cap_q.size(); fsb = fs_cnt;
    frm_q.delete(); frm_q.push_back(8'h12); frm_q.push_back(8'h34); frm_q.push_back(8'h56);
    send_frame(1'b1);
    expect_frame();
    wait_sent(fsb + 1);
    check("latency", req_cyc_q[base] - push_cyc, 2);
    idle(30);
    check("frame1_once", fs_cnt, fsb + 1);
    compare_capture("frame1");

    // back-to-back frames
    base = cap_q.size(); fsb = fs_cnt;
    frm_q.delete(); frm_q.push_back(8'h01);
    send_frame(1'b1);
    expect_frame();
    idx = base + exp_q.size();
    frm_q.delete(); frm_q.push_back(8'h02); frm_q.push_back(8'h03);
    send_frame(1'b1);
    expect_frame();
    wait_sent(fsb + 2);
    check("b2b_gap", (req_cyc_q[idx] - fs_cyc_q[fsb]) >= 13, 1);
    compare_capture("b2b");

    // oversize frame: forced start on full FIFO
    idle(20);
    base = cap_q.size(); fsb = fs_cnt;
    frm_q.delete();
    for (int i = 0; i < 16; i++) frm_q.push_back(8'(8'h10 + i));
    send_frame(1'b0);
    check("full_in_ready", in_ready, 0);
    check("full_not_started", cap_q.size(), base);
    push_byte(8'hAA, 1'b1);
    frm_q.push_back(8'hAA);
    expect_frame();
    wait_sent(fsb + 1);
    idle(30);
    check("forced_once", fs_cnt, fsb + 1);
    compare_capture("forced");

    // reset during DATA byte 0x34
    base = cap_q.size(); fsb = fs_cnt;
    frm_q.delete(); frm_q.push_back(8'h12); frm_q.push_back(8'h34); frm_q.push_back(8'h56);
    send_frame(1'b1);
    t = 0;
    while (cap_q.size() < base + 5 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached_34", cap_q.size() >= base + 5, 1);
    if (cap_q.size() >= base + 5) check("abort_byte", cap_q[base+4], 8'h34);
    reset = 1'b1;
    #1;
    check("abort_ser_req", ser_req, 0);
    check("abort_busy", busy, 0);
    check("abort_ser_data", ser_data, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_frame_sent", frame_sent, 0);
    idle(3);
    reset = 1'b0;
    idle(60);
    check("abort_no_req", cap_q.size(), base + 5);
    check("abort_no_sent", fs_cnt, fsb);
    cap_rd = cap_q.size();
    frm_q.delete(); frm_q.push_back(8'h5A);
    send_frame(1'b1);
    expect_frame();
    wait_sent(fsb + 1);
    compare_capture("post_reset");

    // handshake integrity over the whole run
    check("req_one_cycle", run_err, 0);
    check("no_early_advance", early_err, 0);
    check("data_held", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
